// File: rtl/mem_scan_reader.sv
// mem_scan_reader: walks an address range of a synchronous-read RAM, capturing
// each word and holding address/data on display outputs for a dwell period.
//
// state  | meaning
// IDLE   | waiting for start; display keeps the last captured word
// ISSUE  | read strobe asserted at the current address
// WAIT   | RAM returns data; captured into display registers at cycle end
// HOLD   | display held for max(dwell,1) cycles, then advance or finish
// DONE   | one-cycle done pulse, back to IDLE
module mem_scan_reader #(
  parameter int WORD_SIZE   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [ADDR_WIDTH-1:0]  end_addr,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd_en,
  input  logic [WORD_SIZE-1:0]   mem_rd_data,
  output logic [ADDR_WIDTH-1:0]  disp_addr,
  output logic [WORD_SIZE-1:0]   disp_data,
  output logic                   disp_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cur;
  logic [ADDR_WIDTH-1:0]  end_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] cnt;
  logic                   rd_en_q;

  // stop must kill a read issued in the same cycle, so the strobe is gated
  // combinationally rather than waiting for the next edge
  assign mem_rd_en = rd_en_q & ~stop;

  // scan sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur        <= '0;
      end_q      <= '0;
      dwell_q    <= '0;
      cnt        <= '0;
      rd_en_q    <= 1'b0;
      mem_addr   <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (state != S_IDLE && stop) begin
      state      <= S_IDLE;
      rd_en_q    <= 1'b0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            cur        <= start_addr;
            end_q      <= end_addr;
            dwell_q    <= dwell;
            mem_addr   <= start_addr;
            rd_en_q    <= 1'b1;
            disp_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_en_q <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          disp_data  <= mem_rd_data;
          disp_addr  <= cur;
          disp_valid <= 1'b1;
          // a zero dwell still holds the word for one cycle
          cnt        <= (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt == DWELL_WIDTH'(1)) begin
            if (cur == end_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur      <= cur + 1'b1;
              mem_addr <= cur + 1'b1;
              rd_en_q  <= 1'b1;
              state    <= S_ISSUE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader with a behavioural synchronous-read RAM.
module tb_mem_scan_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic [23:0] dwell;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic [7:0]  disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;
  int rd_cnt;
  int done_cnt;

  logic [7:0] ram [256];

  mem_scan_reader #(.WORD_SIZE(8), .ADDR_WIDTH(8), .DWELL_WIDTH(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .dwell       (dwell),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the strobed address
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  // count strobes and done pulses seen on active edges
  always @(posedge clk) begin
    if (rst_n && mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (rst_n && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full scan and checks every cycle against the hand-derived schedule:
  // ISSUE, WAIT, then max(dwell,1) HOLD cycles per word, then one DONE cycle.
  // exp_data holds the expected word for each visited address, in order.
  task automatic scan(input logic [7:0] sa, input logic [7:0] ea, input int dw,
                      input int n, input logic [7:0] exp_data [4], input bit poke);
    int rd0, dn0, hd;
    logic [7:0] a;
    rd0 = rd_cnt;
    dn0 = done_cnt;
    start_addr = sa; end_addr = ea; dwell = 24'(dw); start = 1'b1;
    tick();
    start = 1'b0;
    hd = (dw == 0) ? 1 : dw;
    a = sa;
    for (int k = 0; k < n; k++) begin
      chk("issue_rd_en", 32'(mem_rd_en), 32'd1);
      chk("issue_addr", 32'(mem_addr), 32'(a));
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_valid", 32'(disp_valid), (k == 0) ? 32'd0 : 32'd1);
      tick();
      chk("wait_rd_en", 32'(mem_rd_en), 32'd0);
      chk("wait_addr", 32'(mem_addr), 32'(a));
      tick();
      for (int h = 0; h < hd; h++) begin
        if (poke) begin
          start = 1'b1; start_addr = 8'h00; end_addr = 8'hFF; dwell = 24'd9;
        end
        chk("hold_valid", 32'(disp_valid), 32'd1);
        chk("hold_addr", 32'(disp_addr), 32'(a));
        chk("hold_data", 32'(disp_data), 32'(exp_data[k]));
        chk("hold_rd_en", 32'(mem_rd_en), 32'd0);
        chk("hold_done", 32'(done), 32'd0);
        tick();
      end
      a = a + 8'd1;
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_valid", 32'(disp_valid), 32'd1);
    chk("read_count", 32'(rd_cnt - rd0), 32'(n));
    chk("done_count", 32'(done_cnt - dn0), 32'd1);
  endtask

  logic [7:0] d1 [4];
  logic [7:0] dw2 [4];
  logic [7:0] ds [4];
  int rd_snap, dn_snap;

  initial begin
    n_cmp = 0; n_bad = 0; rd_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[8'h10] = 8'hA1; ram[8'h11] = 8'hB2; ram[8'h12] = 8'hC3; ram[8'h13] = 8'hD4;
    ram[8'hFE] = 8'h11; ram[8'hFF] = 8'h22; ram[8'h00] = 8'h33; ram[8'h01] = 8'h44;
    ram[8'h55] = 8'h3C;
    ram[8'h20] = 8'h9E; ram[8'h21] = 8'h6F;
    d1  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    dw2 = '{8'h11, 8'h22, 8'h33, 8'h44};
    ds  = '{8'h3C, 8'h00, 8'h00, 8'h00};
    mem_rd_data = 8'h00;
    start = 1'b0; stop = 1'b0; start_addr = 8'h00; end_addr = 8'h00; dwell = 24'd0;

    rst_n = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_disp", {16'd0, disp_addr, disp_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic range with dwell 4
    scan(8'h10, 8'h13, 4, 4, d1, 1'b0);
    // wrap-around with zero dwell
    scan(8'hFE, 8'h01, 0, 4, dw2, 1'b0);
    // single word
    scan(8'h55, 8'h55, 2, 1, ds, 1'b0);

    // stop during HOLD of the second word
    rd_snap = rd_cnt; dn_snap = done_cnt;
    start_addr = 8'h10; end_addr = 8'h13; dwell = 24'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_stop_addr", 32'(disp_addr), 32'h11);
    stop = 1'b1;
    #1;
    chk("stop_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_valid", 32'(disp_valid), 32'd0);
    chk("stop_addr", 32'(disp_addr), 32'h11);
    chk("stop_data", 32'(disp_data), 32'hB2);
    for (int i = 0; i < 10; i++) tick();
    chk("stop_reads", 32'(rd_cnt - rd_snap), 32'd2);
    chk("stop_no_done", 32'(done_cnt - dn_snap), 32'd0);

    // start and stop together: stays idle
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("ss_reads", 32'(rd_cnt - rd_snap), 32'd2);

    // reset asserted in WAIT
    start_addr = 8'h10; end_addr = 8'h13; dwell = 24'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_disp", {15'd0, disp_valid, disp_addr, disp_data}, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #4;
    rst_n = 1'b1;
    tick();

    // dwell 1 with start pulses and changed inputs while busy
    d1 = '{8'h9E, 8'h6F, 8'h00, 8'h00};
    scan(8'h20, 8'h21, 1, 2, d1, 1'b1);
    chk("poke_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
